// File: rtl/recibidor_serial_if.sv
// Receive-side serial link bundle: serial bit in, deserialized byte out, lock status and FSM state.
// valid_out is a level: it is high for the 8-cycle byte slot after a data byte completes, and there is no ready/back-pressure.
interface recibidor_serial_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [1:0] state_dbg;

  modport master (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output state_dbg
  );

  modport slave (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  state_dbg
  );
endinterface

// File: rtl/recibidor_serial.sv
// Serial receiver: finds byte alignment on COM, locks after BC_REQ aligned COMs,
// then deserializes MSB-first and delivers non-COM/IDLE bytes on data_out/valid_out.
module recibidor_serial #(
  parameter logic [7:0]  COM    = 8'hBC,
  parameter logic [7:0]  IDLE   = 8'h7C,
  parameter int unsigned BC_REQ = 4
) (
  input logic           clk_8f,
  input logic           reset,
  recibidor_serial_if.master bus
);

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    ALIGNING = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  localparam logic [4:0] BC_REQ_W = 5'(BC_REQ);

  state_t     state, state_nxt;
  logic [7:0] sr;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] bc_cnt, bc_cnt_nxt;
  logic [7:0] data_q, data_nxt;
  logic       valid_q, valid_nxt;
  logic       active_q, active_nxt;
  logic [7:0] cand;
  logic       slot_done;
  logic [4:0] bc_inc;

  // cand is the byte that ends with the bit sampled at this edge
  assign cand      = {sr[6:0], bus.data_in};
  assign slot_done = (bit_cnt == 3'd7);
  assign bc_inc    = {1'b0, bc_cnt} + 5'd1;

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state    <= SEARCH;
      sr       <= 8'h00;
      bit_cnt  <= 3'd0;
      bc_cnt   <= 4'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= cand;
      bit_cnt  <= bit_cnt_nxt;
      bc_cnt   <= bc_cnt_nxt;
      data_q   <= data_nxt;
      valid_q  <= valid_nxt;
      active_q <= active_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt + 3'd1;
    bc_cnt_nxt  = bc_cnt;
    case (state)
      SEARCH: begin
        bit_cnt_nxt = 3'd0;
        if (cand == COM) begin
          bc_cnt_nxt = 4'd1;
          state_nxt  = (BC_REQ == 1) ? ACTIVE : ALIGNING;
        end
      end
      ALIGNING: begin
        if (slot_done) begin
          if (cand == COM) begin
            bc_cnt_nxt = bc_inc[3:0];
            if (bc_inc == BC_REQ_W) state_nxt = ACTIVE;
          end else begin
            // the broken slot is dropped; sliding search resumes at the next bit
            state_nxt   = SEARCH;
            bc_cnt_nxt  = 4'd0;
            bit_cnt_nxt = 3'd0;
          end
        end
      end
      ACTIVE: begin
        bc_cnt_nxt = bc_cnt;
      end
      default: begin
        state_nxt   = SEARCH;
        bit_cnt_nxt = 3'd0;
        bc_cnt_nxt  = 4'd0;
      end
    endcase
  end

  always_comb begin
    data_nxt   = data_q;
    valid_nxt  = valid_q;
    active_nxt = (state_nxt == ACTIVE);
    if (state == ACTIVE && slot_done) begin
      if (cand == COM || cand == IDLE) begin
        valid_nxt = 1'b0;
      end else begin
        data_nxt  = cand;
        valid_nxt = 1'b1;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;
  assign bus.state_dbg = state;

endmodule

// File: doc/recibidor_serial.md
Name: recibidor_serial

Overview:
- Receive end of the PHY serial link: takes the 1-bit serial stream produced by the transmit path (8-bit data + valid stage, then parallel-to-serial), all in the clk_8f domain.
- Finds byte alignment on the COM symbol and declares the link active after BC_REQ consecutive aligned COMs.
- Deserializes MSB-first into 8-bit words, strips COM/IDLE symbols, and presents data_out with valid_out.

Parameters:
COM, 8'hBC, comma/alignment symbol
IDLE, 8'h7C, idle filler symbol; never delivered as data
BC_REQ, 4, consecutive aligned COM bytes (including the first detected) needed to enter ACTIVE; legal range 1..15

Ports:
clk_8f  input  1  bit clock; one serial bit per rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk_8f
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  last delivered data byte
valid_out  output  1  high while data_out holds a byte received in the most recent byte slot
active  output  1  high in state ACTIVE

Behaviour:
- Reset (reset=1 at an edge) clears everything and overrides all other activity, including mid-byte and mid-alignment:
  - state=SEARCH, shift register sr=0, bit_cnt=0, bc_cnt=0.
  - data_out=8'h00, valid_out=0, active=0.
  - First data_in bit sampled is at the first edge with reset=0.
- Every non-reset edge: sr <= {sr[6:0], data_in}. Define cand = {sr[6:0], data_in}, the byte completed at this edge.
- bit_cnt (3 bits) increments every edge in ALIGNING/ACTIVE. A byte slot completes at an edge where bit_cnt==7; bit_cnt wraps 7->0.
- SEARCH:
  - Bit-by-bit sliding compare every edge.
  - If cand==COM: go to ALIGNING, bit_cnt<=0, bc_cnt<=1. If BC_REQ==1, go directly to ACTIVE instead.
  - Otherwise stay in SEARCH; bit_cnt is not used.
- ALIGNING, at slot completion only:
  - cand==COM: bc_cnt<=bc_cnt+1. When bc_cnt+1==BC_REQ, go to ACTIVE.
  - cand!=COM: go to SEARCH, bc_cnt<=0. The COM check in SEARCH starts at the next edge; the misaligned byte is not re-scanned.
- ACTIVE, at slot completion:
  - cand is COM or IDLE: valid_out<=0, data_out holds its value.
  - Otherwise: data_out<=cand, valid_out<=1.
  - Between completions, outputs hold, so valid_out is an 8-cycle-wide level per byte slot.
  - ACTIVE persists until reset; there is no loss-of-lock detection.
- active: registered, =1 from the edge entering ACTIVE onward. valid_out and data_out change only in ACTIVE.
- Latency: the last bit of a data byte sampled at edge E gives data_out/valid_out updated immediately after E (0 extra cycles), then held until E+8.
- A COM appearing at a non-slot offset while in ALIGNING/ACTIVE is ignored; alignment is never re-derived outside SEARCH.

Test Plan:
- Reset: hold reset=1 for 3 edges with random data_in -> data_out=00, valid_out=0, active=0. Deassert -> still 0 until a COM is seen.
- Lock-up (BC_REQ=4): send BC,BC,BC,BC,A5 MSB-first from the first post-reset edge. Required: ALIGNING after edge 8; active=1 after edge 32; data_out=A5, valid_out=1 after edge 40, held through edge 47.
- Offset alignment: 3 junk bits (1,0,1), then BC x4, 3C -> active after edge 35, data_out=3C valid after edge 43.
- Alignment break: BC,BC,55,BC,BC,BC,BC,12 -> return to SEARCH after edge 24, active after edge 56, data_out=12 after edge 64.
- Filtering in ACTIVE: after lock send 81,7C,BC,FF -> valid_out sequence per slot 1,0,0,1. data_out shows 81, holds 81 through the 7C and BC slots, then shows FF.
- Reset mid-operation: assert reset at the 5th bit of a data byte while ACTIVE -> outputs 0 and active=0 after that edge. Relock requires a full BC_REQ COM sequence.
